fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the write port of the async FIFO among NUM_REQ requesters in the write-clock domain.
- Arbitration is round-robin with bounded bursts.
- Drives the FIFO wr_en/wdata pair and honours its full flag, so the FIFO never sees an overflow write.
- Sits between the producer blocks and the FIFO write port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, data width, equal to the FIFO WIDTH
MAX_BURST, 4, maximum beats written per grant before re-arbitration (1..16)
CNT_W, 4, burst counter width, must satisfy 2**CNT_W >= MAX_BURST

Ports:
clk_i  input  1  write-domain clock, same net as the FIFO write clock
rst_n_i  input  1  asynchronous reset, active low
req_i  input  NUM_REQ  per-requester valid; held high while data is pending
wdata_i  input  NUM_REQ*WIDTH  requester n data at bits [n*WIDTH +: WIDTH]
ack_o  output  NUM_REQ  per-requester beat accepted this cycle (combinational)
full_i  input  1  FIFO full flag
wr_en_o  output  1  FIFO write enable (combinational)
wdata_o  output  WIDTH  FIFO write data (combinational)
busy_o  output  1  a grant is held
owner_o  output  NUM_REQ  one-hot current grant; 0 when idle

Behaviour:
- Reset: clk_i single clock; rst_n_i asynchronous, active-low.
  - On rst_n_i low: state=IDLE, grant=0, cnt=0, last=NUM_REQ-1.
  - Therefore busy_o=0, owner_o=0, wr_en_o=0, ack_o=0, wdata_o=0.
  - Reset mid-burst aborts the grant immediately. A beat in flight is not written, because wr_en_o drops asynchronously.
- State IDLE:
  - If any req_i bit is set, choose the first set bit searching from last+1 upward, with modulo NUM_REQ wrap.
  - Register grant to that one-hot value, set cnt=0, last=index, then go to GRANT.
  - If no request is pending, stay in IDLE. No writes occur in IDLE.
- State GRANT, with owner o:
  - fire = req_i[o] & ~full_i.
  - wr_en_o = fire; ack_o[o] = fire; all other ack_o bits are 0.
  - wdata_o = wdata_i slice o when in GRANT, else 0.
  - On fire:
    - cnt increments.
    - If cnt == MAX_BURST-1, release: go to IDLE, grant=0, cnt=0.
  - If req_i[o]=0, release to IDLE that cycle with no write.
  - If req_i[o]=1 and full_i=1: stall. Hold grant and cnt, no write, no ack. Stalls are unbounded.
- Latency and throughput:
  - req rising in IDLE at edge t gives grant at t+1, so the first ack is possible in the cycle after edge t+1.
  - Each release costs one IDLE bubble cycle.
  - Peak rate is MAX_BURST beats per MAX_BURST+1 cycles.
- Handshake:
  - Requester data must be stable while req is high.
  - A beat transfers in any cycle where ack_o[n]=1.
  - The requester may drop req or present new data in the following cycle.
- Fairness: after owner o is released, o has lowest priority in the next arbitration. Any requester waits at most (NUM_REQ-1)*(MAX_BURST+1) non-stalled cycles.
- Invariants:
  - wr_en_o & full_i is never 1.
  - At most one ack_o bit is set.
  - owner_o is one-hot or zero.
  - wr_en_o is 1 only when some ack_o bit is 1.
- Requests that arrive while another requester owns the grant wait. Requests dropped before being granted are lost silently; requesters must hold req.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=1'b0, ST_GRANT=1'b1) and a function for one-hot to index conversion.
- Sub-module rr_pick:
  - Purely combinational round-robin picker.
  - Inputs: req, last index. Outputs: one-hot grant, index, any.
  - Reused later by the read-side scheduler.
- The top level holds the state register, counter, last-pointer and output muxing.

Test Plan:
- Single requester: req_i=4'b0001 for 6 cycles, data 8'hA0..A5, full_i=0.
  - Expect bursts of beats A0..A3 (4 acks), one bubble, then A4, A5.
  - Exactly 6 writes total; busy_o drops when req_i drops.
- All requesting: req_i=4'b1111 held, data 8'h10*n+k.
  - Grant order 0,1,2,3,0; each burst is 4 beats with one idle cycle between bursts.
  - Never two ack bits at once.
- Full backpressure: owner 2 mid-burst after 2 beats, full_i=1 for 5 cycles.
  - Expect wr_en_o=0 and ack_o=0 for 5 cycles while owner_o stays 4'b0100.
  - After full_i falls, exactly 2 more beats, then release.
- Early drop: requester 1 drops req after 1 beat.
  - Expect release to IDLE that cycle with no write.
  - Next grant goes to requester 2 or 3 when pending, with requester 1 at lowest priority.
- Reset mid-burst: rst_n_i low for 3 cycles during a write.
  - Expect wr_en_o, busy_o and owner_o to be 0 immediately.
  - After release with req_i=4'b1010, the first grant goes to requester 1.
- End-to-end with the async FIFO (DEPTH 16, wr 10 ns, rd 14 ns): 4 requesters, 100 random beats with random gaps.
  - FIFO wr_error_o never asserted.
  - Read stream preserves per-requester order with no loss or duplication.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter and its round-robin picker.
// Contains the FSM state encoding and a one-hot to index helper.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    // Valid only for one-hot or zero inputs; zero maps to index 0.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping modulo N.
// Shared with the read-side scheduler, so it carries no state of its own.
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        // Offset 1 first, so the previous owner is considered last.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_i) + k) % N;
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters,
// with bursts bounded to MAX_BURST beats and writes suppressed while the FIFO is full.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]       ack_o,
    input  logic                     full_i,
    output logic                     wr_en_o,
    output logic [WIDTH-1:0]         wdata_o,
    output logic                     busy_o,
    output logic [NUM_REQ-1:0]       owner_o
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   last_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic [IDX_W-1:0]   own_idx;
    logic               in_grant;
    logic               own_req;
    logic               fire;

    fifo_wr_arbiter_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i  (req_i),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign own_idx  = IDX_W'(onehot_to_idx(MAX_REQ'(grant_q)));
    assign in_grant = (state_q == ST_GRANT);
    assign own_req  = req_i[own_idx];
    // Gating on the live state means an async reset kills a beat in flight.
    assign fire     = in_grant & own_req & ~full_i;

    assign wr_en_o  = fire;
    assign ack_o    = {NUM_REQ{fire}} & grant_q;
    assign wdata_o  = in_grant ? wdata_i[own_idx*WIDTH +: WIDTH] : '0;
    assign busy_o   = in_grant;
    assign owner_o  = grant_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_q <= ST_GRANT;
                        grant_q <= pick_gnt;
                        cnt_q   <= '0;
                        last_q  <= pick_idx;
                    end
                end
                ST_GRANT: begin
                    if (!own_req) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        cnt_q   <= '0;
                    end else if (fire) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= ST_IDLE;
                            grant_q <= '0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requester models feed beats, expected beats
// are queued as stimulus is loaded and retired as the arbiter writes them.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req = '0;
    logic [NUM_REQ*WIDTH-1:0] wdata = '0;
    logic [NUM_REQ-1:0]       ack;
    logic                     full = 1'b0;
    logic                     wr_en;
    logic [WIDTH-1:0]         wdata_out;
    logic                     busy;
    logic [NUM_REQ-1:0]       owner;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .req_i   (req),
        .wdata_i (wdata),
        .ack_o   (ack),
        .full_i  (full),
        .wr_en_o (wr_en),
        .wdata_o (wdata_out),
        .busy_o  (busy),
        .owner_o (owner)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nwr   = 0;

    logic [WIDTH-1:0] src   [NUM_REQ][$];
    logic [WIDTH-1:0] exp_r [NUM_REQ][$];
    logic [15:0]      exp_q [$];
    int               wr_cyc[$];
    int               gap   [NUM_REQ];
    logic [NUM_REQ-1:0] en    = '0;
    logic [NUM_REQ-1:0] ack_s = '0;
    int gap_max   = 0;
    bit ordered   = 1'b1;
    bit rand_full = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic drive();
        for (int n = 0; n < NUM_REQ; n++) begin
            if (en[n] && src[n].size() > 0 && gap[n] == 0) begin
                req[n] = 1'b1;
                wdata[n*WIDTH +: WIDTH] = src[n][0];
            end else begin
                req[n] = 1'b0;
                wdata[n*WIDTH +: WIDTH] = '0;
            end
        end
    endtask

    task automatic clear_all();
        for (int n = 0; n < NUM_REQ; n++) begin
            src[n].delete();
            exp_r[n].delete();
            gap[n] = 0;
        end
        exp_q.delete();
        ack_s = '0;
        en    = '0;
    endtask

    task automatic load(input int n, input logic [WIDTH-1:0] d);
        src[n].push_back(d);
        exp_r[n].push_back(d);
        exp_q.push_back({8'(n), d});
    endtask

    // Observe the cycle just before the next active edge.
    task automatic sample();
        logic [7:0]  id;
        logic [15:0] e;
        @(negedge clk);
        cyc++;
        ack_s = ack;
        chk("inv_wr_full", 32'(wr_en & full), 0);
        chk("inv_ack_count", $countones(ack), wr_en ? 1 : 0);
        if (!busy) chk("idle_outputs", 32'({owner, wdata_out}), 0);
        if (wr_en) begin
            id = 8'hFF;
            for (int n = 0; n < NUM_REQ; n++) if (ack[n]) id = 8'(n);
            chk("wr_owner", 32'(owner), 32'(ack));
            wr_cyc.push_back(cyc);
            nwr++;
            if (ordered) begin
                chk("wr_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wr_beat", 32'({id, wdata_out}), 32'(e));
                end
            end else if (id < NUM_REQ) begin
                chk("wr_pending_req", 32'(exp_r[id].size() > 0), 1);
                if (exp_r[id].size() > 0) chk("wr_beat_req", 32'(wdata_out), 32'(exp_r[id].pop_front()));
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (gap[n] > 0) gap[n]--;
            if (ack_s[n]) begin
                src[n].delete(0);
                gap[n] = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            end
        end
        ack_s = '0;
        if (rand_full) full = ($urandom_range(0, 3) == 0);
        drive();
    endtask

    task automatic run_until(input int target, input int limit, input string tag);
        int k = 0;
        while (nwr < target && k < limit) begin
            sample();
            advance();
            k++;
        end
        chk(tag, nwr, target);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        full  = 1'b0;
        clear_all();
        drive();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int wb;

        do_reset();
        sample();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_wdata", 32'(wdata_out), 0);
        advance();

        // Single requester: one full burst, a bubble, then the tail.
        do_reset();
        en = 4'b0001;
        for (int k = 0; k < 6; k++) load(0, 8'hA0 + 8'(k));
        drive();
        base = nwr; wb = wr_cyc.size();
        run_until(base + 6, 50, "t1_writes");
        for (int i = 1; i < 6; i++)
            chk("t1_gap", wr_cyc[wb+i] - wr_cyc[wb+i-1], (i % 4 == 0) ? 2 : 1);
        sample();
        chk("t1_drop_busy", 32'(busy), 1);
        chk("t1_drop_wr", 32'(wr_en), 0);
        advance();
        sample();
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_owner", 32'(owner), 0);
        advance();

        // All requesting: two rounds of 4-beat bursts in order 0,1,2,3.
        do_reset();
        en = 4'b1111;
        for (int n = 0; n < NUM_REQ; n++)
            for (int k = 0; k < 8; k++) src[n].push_back(8'(16*n + k));
        for (int b = 0; b < 2; b++)
            for (int n = 0; n < NUM_REQ; n++)
                for (int k = 0; k < 4; k++) exp_q.push_back({8'(n), 8'(16*n + 4*b + k)});
        drive();
        base = nwr; wb = wr_cyc.size();
        run_until(base + 32, 200, "t2_writes");
        for (int i = 1; i < 32; i++)
            chk("t2_gap", wr_cyc[wb+i] - wr_cyc[wb+i-1], (i % 4 == 0) ? 2 : 1);

        // Full backpressure on owner 2 after two beats.
        do_reset();
        en = 4'b0100;
        for (int k = 0; k < 4; k++) load(2, 8'hC0 + 8'(k));
        drive();
        base = nwr; wb = wr_cyc.size();
        run_until(base + 2, 20, "t3_pre");
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("t3_stall_wr", 32'(wr_en), 0);
            chk("t3_stall_ack", 32'(ack), 0);
            chk("t3_stall_owner", 32'(owner), 32'(4'b0100));
            advance();
            if (i == 4) full = 1'b0;
        end
        run_until(base + 4, 20, "t3_post");
        chk("t3_stall_gap", wr_cyc[wb+2] - wr_cyc[wb+1], 6);
        chk("t3_tail_gap", wr_cyc[wb+3] - wr_cyc[wb+2], 1);
        sample();
        chk("t3_release", 32'({busy, owner}), 0);
        advance();

        // Early drop by requester 1; then 2 and 3 in turn.
        do_reset();
        en = 4'b1110;
        load(1, 8'hB0);
        load(2, 8'h20); load(2, 8'h21);
        load(3, 8'h30); load(3, 8'h31);
        drive();
        base = nwr; wb = wr_cyc.size();
        run_until(base + 5, 60, "t4_writes");
        chk("t4_gap_drop", wr_cyc[wb+1] - wr_cyc[wb], 3);
        chk("t4_gap_b2", wr_cyc[wb+2] - wr_cyc[wb+1], 1);
        chk("t4_gap_drop2", wr_cyc[wb+3] - wr_cyc[wb+2], 3);
        chk("t4_gap_b3", wr_cyc[wb+4] - wr_cyc[wb+3], 1);

        // Reset in the middle of a write cycle.
        do_reset();
        en = 4'b0001;
        for (int k = 0; k < 4; k++) load(0, 8'hE0 + 8'(k));
        drive();
        base = nwr;
        for (int k = 0; k < 20 && nwr == base; k++) begin
            sample();
            if (nwr == base) advance();
        end
        chk("t5_first_write", nwr, base + 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_wr_en", 32'(wr_en), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_owner", 32'(owner), 0);
        chk("t5_rst_ack", 32'(ack), 0);
        clear_all();
        en = 4'b1111;
        load(1, 8'hF0);
        load(3, 8'hF1);
        drive();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        base = nwr;
        run_until(base + 2, 30, "t5_after_rst");

        // Random gaps and random full: per-requester order, no loss or duplication.
        do_reset();
        ordered   = 1'b0;
        gap_max   = 3;
        rand_full = 1'b1;
        en = 4'b1111;
        for (int n = 0; n < NUM_REQ; n++)
            for (int k = 0; k < 25; k++) load(n, 8'($urandom_range(0, 255)));
        drive();
        base = nwr;
        run_until(base + 100, 4000, "t6_writes");
        rand_full = 1'b0;
        full = 1'b0;
        for (int n = 0; n < NUM_REQ; n++) chk("t6_leftover", exp_r[n].size(), 0);
        sample();
        sample();
        chk("t6_no_extra", nwr, base + 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
